// File: rtl/demux_dispatch_ctrl.sv
// rtl/demux_dispatch_ctrl.sv - one-entry buffer dispatching words to one of four channels
module demux_dispatch_ctrl #(
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 8,
    parameter int STALL_MAX = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              mode,
    input  logic [1:0]        cfg_sel,
    input  logic [3:0]        out_ready,
    output logic [3:0]        out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        selector,
    output logic [CNT_W-1:0]  sent_cnt,
    output logic              busy
);

    localparam int SW = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic           cap_mode;
    logic [1:0]     rr_ptr;
    logic [SW-1:0]  stall_cnt;
    logic           hit;
    logic           expire;

    assign hit    = out_ready[selector];
    // Only round-robin words give up on a stalled channel.
    assign expire = !cap_mode && (stall_cnt == STALL_LAST);

    assign in_ready  = rstn && (state == IDLE);
    assign busy      = (state == SEND);
    assign out_valid = (state == SEND) ? (4'b0001 << selector) : 4'b0000;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = SEND;
            SEND:    if (hit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_data  <= '0;
            selector  <= 2'd0;
            sent_cnt  <= '0;
            rr_ptr    <= 2'd0;
            stall_cnt <= '0;
            cap_mode  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_data  <= in_data;
                        selector  <= mode ? cfg_sel : rr_ptr;
                        cap_mode  <= mode;
                        stall_cnt <= '0;
                    end
                end
                SEND: begin
                    // Delivery wins over retarget when both fall on the same edge.
                    if (hit) begin
                        sent_cnt <= sent_cnt + CNT_W'(1);
                        if (!cap_mode) begin
                            rr_ptr <= selector + 2'd1;
                        end
                    end else if (expire) begin
                        selector  <= selector + 2'd1;
                        stall_cnt <= '0;
                    end else if (stall_cnt != STALL_LAST) begin
                        stall_cnt <= stall_cnt + SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// tb/tb_demux_dispatch_ctrl.sv - randomized and directed checks against a transaction-level model
module tb_demux_dispatch_ctrl;

    localparam int DATA_W    = 8;
    localparam int CNT_W     = 8;
    localparam int STALL_MAX = 4;

    logic              clk;
    logic              rstn;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mode;
    logic [1:0]        cfg_sel;
    logic [3:0]        out_ready;
    logic [3:0]        out_valid;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        selector;
    logic [CNT_W-1:0]  sent_cnt;
    logic              busy;

    demux_dispatch_ctrl #(
        .DATA_W    (DATA_W),
        .CNT_W     (CNT_W),
        .STALL_MAX (STALL_MAX)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mode      (mode),
        .cfg_sel   (cfg_sel),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .selector  (selector),
        .sent_cnt  (sent_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model: a word remembers its starting channel and how many edges it has waited;
    // the channel it is offered on follows from that by division.
    int m_busy, m_data, m_mode, m_start, m_waited;
    int m_cnt, m_rr, m_lastsel, m_caps, mc;
    int m_log_ch[$];
    int m_log_d[$];
    int dut_log_d[$];
    int n_v4, n_v2;

    function automatic int m_sel();
        if (m_busy != 0)
            return (m_start + ((m_mode != 0) ? 0 : m_waited / STALL_MAX)) % 4;
        return m_lastsel;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rstn) begin
            m_busy = 0; m_data = 0; m_mode = 0; m_start = 0; m_waited = 0;
            m_cnt = 0; m_rr = 0; m_lastsel = 0;
        end else if (m_busy == 0) begin
            if (in_valid) begin
                m_busy = 1; m_data = in_data; m_mode = mode;
                m_start = mode ? int'(cfg_sel) : m_rr;
                m_waited = 0; m_caps++;
            end
        end else begin
            mc = m_sel();
            if (out_ready[mc]) begin
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                if (m_mode == 0) m_rr = (mc + 1) % 4;
                m_lastsel = mc; m_busy = 0;
                m_log_ch.push_back(mc);
                m_log_d.push_back(m_data);
            end else begin
                m_waited++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, (rstn && m_busy == 0));
            chk("busy", busy, m_busy);
            chk("out_valid", out_valid, (m_busy != 0) ? (32'd1 << m_sel()) : 32'd0);
            chk("out_data", out_data, m_data);
            chk("selector", selector, m_sel());
            chk("sent_cnt", sent_cnt, m_cnt);
            chk("rr_ptr", dut.rr_ptr, m_rr);
            if (out_valid == 4'b0100) n_v4++;
            if (out_valid == 4'b0010) n_v2++;
            if (rstn && |(out_valid & out_ready)) dut_log_d.push_back(int'(out_data));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input int d, input bit md, input int cs);
        int n;
        n = m_caps;
        in_data = d[DATA_W-1:0]; mode = md; cfg_sel = cs[1:0]; in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            cyc(1);
            if (m_caps != n) break;
        end
        chk("send_timeout", (m_caps != n), 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200; k++) begin
            if (m_busy == 0) break;
            cyc(1);
        end
        chk("idle_timeout", m_busy, 0);
    endtask

    int idx, d, a5_cnt;

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_data = '0; mode = 1'b0;
        cfg_sel = 2'd0; out_ready = 4'b0000;
        cyc(1);
        chk_en = 1'b1;
        cyc(1);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_selector", selector, 0);
        chk("rst_sent_cnt", sent_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        @(posedge clk); #1;

        // Reset while a word is held
        rstn = 1'b1;
        send_word(8'hA5, 1'b0, 0);
        cyc(1);
        rstn = 1'b0;
        cyc(2);
        @(negedge clk);
        chk("t1_out_valid", out_valid, 0);
        chk("t1_busy", busy, 0);
        chk("t1_out_data", out_data, 0);
        chk("t1_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("t1_in_ready_rel", in_ready, 1);
        @(posedge clk); #1;

        // Round-robin, back to back
        out_ready = 4'b1111;
        idx = m_log_ch.size();
        send_word(8'h11, 1'b0, 0);
        send_word(8'h22, 1'b0, 0);
        send_word(8'h33, 1'b0, 0);
        send_word(8'h44, 1'b0, 0);
        send_word(8'h55, 1'b0, 0);
        wait_idle();
        for (int i = 0; i < 5; i++) begin
            chk("t2_ch", m_log_ch[idx+i], i % 4);
            chk("t2_data", m_log_d[idx+i], 8'h11 * (i + 1));
        end
        chk("t2_cnt", sent_cnt, 5);

        // Fixed channel, long stall
        out_ready = 4'b0000;
        n_v4 = 0;
        send_word(8'h3C, 1'b1, 2);
        cyc(10);
        out_ready = 4'b0100;
        wait_idle();
        chk("t3_len", n_v4, 11);
        chk("t3_ch", m_log_ch[$], 2);
        chk("t3_cnt", sent_cnt, 6);
        chk("t3_rr", dut.rr_ptr, 1);

        // Round-robin retarget
        out_ready = 4'b1101;
        n_v2 = 0;
        send_word(8'h77, 1'b0, 0);
        wait_idle();
        chk("t4_len", n_v2, 4);
        chk("t4_ch", m_log_ch[$], 2);
        chk("t4_rr", dut.rr_ptr, 3);

        // Delivery on the same edge a retarget would happen
        out_ready = 4'b1111;
        send_word(8'h01, 1'b0, 0);
        send_word(8'h02, 1'b0, 0);
        wait_idle();
        out_ready = 4'b1101;
        send_word(8'h99, 1'b0, 0);
        cyc(3);
        out_ready = 4'b1111;
        wait_idle();
        chk("t5_ch", m_log_ch[$], 1);
        chk("t5_rr", dut.rr_ptr, 2);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            d = $urandom_range(0, 255);
            if (d == 8'hA5) d = 8'h5A;
            in_valid  = $urandom_range(0, 1);
            in_data   = d[DATA_W-1:0];
            mode      = ($urandom_range(0, 3) == 0);
            cfg_sel   = 2'($urandom_range(0, 3));
            out_ready = 4'($urandom_range(0, 15));
            rstn      = ($urandom_range(0, 49) != 0);
            cyc(1);
        end
        in_valid = 1'b0; rstn = 1'b1;

        // Counter wrap after 256 deliveries
        rstn = 1'b0;
        cyc(2);
        rstn = 1'b1;
        out_ready = 4'b1111;
        idx = m_log_ch.size();
        for (int i = 0; i < 256; i++) begin
            d = $urandom_range(0, 255);
            if (d == 8'hA5) d = 8'h5A;
            send_word(d, 1'b0, 0);
        end
        wait_idle();
        chk("t6_cnt", sent_cnt, 0);
        for (int i = 0; i < 256; i++) chk("t6_ch", m_log_ch[idx+i], i % 4);
        send_word(8'h42, 1'b0, 0);
        wait_idle();
        chk("t6_cnt_next", sent_cnt, 1);
        chk("t6_ch_next", m_log_ch[$], 0);

        a5_cnt = 0;
        foreach (dut_log_d[i]) if (dut_log_d[i] == 8'hA5) a5_cnt++;
        chk("a5_discarded", a5_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
